// File: rtl/plot_pkg.sv
// Shared sizing defaults, sampler state encoding and the y-to-row scale/clip helper.
// Pure definitions: no latency, no flow control.
package plot_pkg;

  localparam int COLS_DEF  = 96;
  localparam int ROWS_DEF  = 64;
  localparam int COL_W_DEF = 7;
  localparam int ROW_W_DEF = 6;

  typedef enum logic [2:0] {IDLE, EVAL, SAMPLE, WRITE, DONE} state_t;

  // Shift at full width before clipping so large y values can never alias into range.
  function automatic int clip_row(input logic signed [47:0] y, input logic [4:0] sh,
                                  input int rows, output logic in_range);
    longint s;
    longint half;
    s        = longint'(y >>> sh);
    half     = longint'(rows / 2);
    in_range = 1'b0;
    if (s > half - 1) begin
      clip_row = 0;
    end else if (s < -half) begin
      clip_row = rows - 1;
    end else begin
      in_range = 1'b1;
      clip_row = int'(half - 1 - s);
    end
  endfunction

endpackage

// File: rtl/plot_col_ram.sv
// Column buffer: simple dual-port RAM, synchronous write, registered read (1 cycle), old data on collision.
// Out-of-range read addresses return 0; no flow control.
module plot_col_ram
  import plot_pkg::*;
#(
  parameter int DEPTH = COLS_DEF,
  parameter int AW    = COL_W_DEF,
  parameter int DW    = ROW_W_DEF + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} < DEPTH_L) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/poly_plot_sampler.sv
// Sweeps x over COLS columns, samples the combinational engine's y, scales/clips it to a row, fills the column buffer.
// 3 cycles per column, done pulses 3*COLS+1 cycles after start; no backpressure, start only taken in IDLE.
module poly_plot_sampler
  import plot_pkg::*;
#(
  parameter int COLS  = COLS_DEF,
  parameter int ROWS  = ROWS_DEF,
  parameter int COL_W = COL_W_DEF,
  parameter int ROW_W = ROW_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [15:0]      x_min,
  input  logic signed [15:0]      x_step,
  input  logic        [4:0]       y_shift,
  output logic signed [15:0]      x_out,
  input  logic signed [47:0]      y_in,
  output logic                    busy,
  output logic                    done,
  output logic                    frame_valid,
  input  logic        [COL_W-1:0] rd_addr,
  output logic        [ROW_W:0]   rd_data
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  state_t             state;
  logic [COL_W-1:0]   col;
  logic signed [15:0] step_q;
  logic [4:0]         shift_q;
  logic signed [47:0] y_reg;
  logic               in_rng;
  int                 row_i;
  logic [ROW_W:0]     wr_data;
  logic               we;

  always_comb begin
    in_rng  = 1'b0;
    row_i   = clip_row(y_reg, shift_q, ROWS, in_rng);
    wr_data = {in_rng, ROW_W'(row_i)};
    we      = (state == WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      col         <= '0;
      x_out       <= '0;
      step_q      <= '0;
      shift_q     <= '0;
      y_reg       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            step_q      <= x_step;
            shift_q     <= y_shift;
            x_out       <= x_min;
            col         <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b1;
            state       <= EVAL;
          end
        end
        // One full cycle for the engine to settle on the new x.
        EVAL: state <= SAMPLE;
        SAMPLE: begin
          y_reg <= y_in;
          state <= WRITE;
        end
        WRITE: begin
          if (col == LAST_COL) begin
            done        <= 1'b1;
            frame_valid <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            col   <= col + 1'b1;
            x_out <= x_out + step_q;
            state <= EVAL;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  plot_col_ram #(
    .DEPTH (COLS),
    .AW    (COL_W),
    .DW    (ROW_W + 1)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .wr_addr (col),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
